// File: rtl/camera_capture_buffer_pkg.sv
// Shared types and constants for the camera capture buffer.
package camera_capture_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    FLUSH,
    DONE
  } cap_state_t;

  localparam int PIX_PER_WORD       = 4;
  localparam int DEFAULT_FIFO_DEPTH = 256;
  localparam int WORD_W             = 32;

endpackage

// File: rtl/camera_capture_buffer_if.sv
// Pixel stream in, packed-word read port out.
interface camera_capture_buffer_if;
  logic        frame_valid;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        capture_read;
  logic [31:0] capture_readdata;

  modport master (output frame_valid, pix_valid, pix_data, capture_read,
                  input  capture_readdata);
  modport slave  (input  frame_valid, pix_valid, pix_data, capture_read,
                  output capture_readdata);
endinterface

// File: rtl/camera_capture_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads 0 when empty.
module capture_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         csi_clk,
  input  logic         csi_reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         pop_ok, push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // a pop frees the slot this cycle, so a push into a full FIFO still lands
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (push_ok && !clr) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/camera_capture_buffer.sv
// Packs an 8-bit pixel stream into little-endian 32-bit words and buffers one frame.
module camera_capture_buffer
  import camera_capture_buffer_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                    csi_clk,
  input  logic                    csi_reset_n,
  input  logic                    capture_start,
  input  logic [15:0]             width,
  input  logic [15:0]             height,
  camera_capture_buffer_if.slave  cap,
  output logic                    capture_done,
  output logic                    overflow,
  output logic                    short_frame
);
  localparam int IDX_W = $clog2(PIX_PER_WORD);

  cap_state_t        state, state_nx;
  logic              start_q, fv_q, rd_q;
  logic [31:0]       total, pix_cnt, cnt_nx;
  logic [WORD_W-1:0] word_q, push_word_q, fifo_wdata, fifo_head;
  logic              push_q;
  logic [IDX_W-1:0]  idx;
  logic              arm, accept, short_set, fifo_push, fifo_pop, fifo_full, fifo_empty, ovf_set;

  assign idx        = pix_cnt[IDX_W-1:0];
  assign arm        = (state == IDLE) && capture_start && !start_q;
  assign accept     = (state == CAPTURE) && cap.frame_valid && cap.pix_valid && (pix_cnt < total);
  assign cnt_nx     = pix_cnt + 32'(accept);
  assign fifo_pop   = cap.capture_read ^ rd_q;
  // full words arrive via push_q; a trailing partial word is pushed straight from word_q
  assign fifo_push  = push_q | ((state == FLUSH) && (idx != '0));
  assign fifo_wdata = push_q ? push_word_q : word_q;
  assign ovf_set    = fifo_push & fifo_full & ~fifo_pop;

  always_comb begin
    state_nx  = state;
    short_set = 1'b0;
    case (state)
      IDLE:       if (arm) state_nx = WAIT_FRAME;
      WAIT_FRAME: if (total == '0) state_nx = DONE;
                  else if (cap.frame_valid && !fv_q) state_nx = CAPTURE;
      CAPTURE: begin
        if (cnt_nx == total) state_nx = FLUSH;
        else if (!cap.frame_valid) begin
          state_nx  = FLUSH;
          short_set = 1'b1;
        end
      end
      FLUSH:      state_nx = DONE;
      DONE:       if (!capture_start) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      fv_q        <= 1'b0;
      rd_q        <= 1'b0;
      total       <= '0;
      pix_cnt     <= '0;
      word_q      <= '0;
      push_word_q <= '0;
      push_q      <= 1'b0;
      overflow    <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= capture_start;
      fv_q    <= cap.frame_valid;
      rd_q    <= cap.capture_read;
      push_q  <= 1'b0;
      if (arm) begin
        total       <= 32'(width) * 32'(height);
        pix_cnt     <= '0;
        word_q      <= '0;
        overflow    <= 1'b0;
        short_frame <= 1'b0;
      end else begin
        if (accept) begin
          pix_cnt <= cnt_nx;
          // starting a word clears the upper bytes so a partial flush is zero-padded
          if (idx == '0) word_q <= {24'h0, cap.pix_data};
          else           word_q[{idx, 3'b000} +: 8] <= cap.pix_data;
          if (idx == IDX_W'(PIX_PER_WORD - 1)) begin
            push_q      <= 1'b1;
            push_word_q <= {cap.pix_data, word_q[23:0]};
          end
        end
        if (ovf_set)   overflow    <= 1'b1;
        if (short_set) short_frame <= 1'b1;
      end
    end
  end

  capture_fifo #(.DEPTH(FIFO_DEPTH), .W(WORD_W)) u_fifo (
    .csi_clk     (csi_clk),
    .csi_reset_n (csi_reset_n),
    .clr         (arm),
    .push        (fifo_push),
    .pop         (fifo_pop),
    .wdata       (fifo_wdata),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head)
  );

  assign cap.capture_readdata = fifo_head;
  assign capture_done         = (state == DONE);

endmodule

// File: tb/tb_camera_capture_buffer.sv
// Directed checks of pixel packing, flush, overflow, pop and reset on a 4-word buffer.
module tb_camera_capture_buffer;
  logic        csi_clk = 1'b0;
  logic        csi_reset_n;
  logic        capture_start;
  logic [15:0] width, height;
  logic        capture_done, overflow, short_frame;
  logic [7:0]  pix_tab [20];
  int          checks = 0;
  int          errors = 0;

  camera_capture_buffer_if cif ();

  camera_capture_buffer #(.FIFO_DEPTH(4)) dut (
    .csi_clk       (csi_clk),
    .csi_reset_n   (csi_reset_n),
    .capture_start (capture_start),
    .width         (width),
    .height        (height),
    .cap           (cif),
    .capture_done  (capture_done),
    .overflow      (overflow),
    .short_frame   (short_frame)
  );

  always #5 csi_clk = ~csi_clk;

  task automatic tick();
    @(posedge csi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic arm(input logic [15:0] w, input logic [15:0] h);
    capture_start = 1'b0;
    tick();
    width         = w;
    height        = h;
    capture_start = 1'b1;
    tick();
  endtask

  task automatic frame(input int n);
    cif.frame_valid = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      cif.pix_valid = 1'b1;
      cif.pix_data  = pix_tab[i];
      tick();
    end
    cif.pix_valid   = 1'b0;
    cif.pix_data    = 8'h00;
    cif.frame_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pop1();
    cif.capture_read = ~cif.capture_read;
    tick();
  endtask

  initial begin
    csi_reset_n      = 1'b0;
    capture_start    = 1'b0;
    width            = '0;
    height           = '0;
    cif.frame_valid  = 1'b0;
    cif.pix_valid    = 1'b0;
    cif.pix_data     = 8'h00;
    cif.capture_read = 1'b0;
    repeat (2) tick();
    chk("rst_readdata", cif.capture_readdata, 32'h0);
    chk("rst_done",     32'(capture_done), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_short",    32'(short_frame), 32'h0);
    csi_reset_n = 1'b1;
    tick();

    // 4x2 frame, pixels 01..08
    for (int i = 0; i < 20; i++) pix_tab[i] = 8'(i + 1);
    arm(16'd4, 16'd2);
    frame(8);
    chk("f42_done",  32'(capture_done), 32'h1);
    chk("f42_short", 32'(short_frame), 32'h0);
    chk("f42_w0",    cif.capture_readdata, 32'h04030201);
    pop1();
    chk("f42_w1",    cif.capture_readdata, 32'h08070605);
    pop1();
    chk("f42_empty", cif.capture_readdata, 32'h0);
    capture_start = 1'b0;
    tick();
    chk("f42_idle",  32'(capture_done), 32'h0);

    // 3x1 frame, partial word padded
    pix_tab[0] = 8'hAA; pix_tab[1] = 8'hBB; pix_tab[2] = 8'hCC;
    arm(16'd3, 16'd1);
    frame(3);
    chk("f31_done",  32'(capture_done), 32'h1);
    chk("f31_w0",    cif.capture_readdata, 32'h00CCBBAA);
    pop1();
    chk("f31_empty", cif.capture_readdata, 32'h0);

    // 4x2 frame cut short after 5 pixels
    for (int i = 0; i < 20; i++) pix_tab[i] = 8'(i + 1);
    arm(16'd4, 16'd2);
    frame(5);
    chk("sh_done",  32'(capture_done), 32'h1);
    chk("sh_short", 32'(short_frame), 32'h1);
    chk("sh_w0",    cif.capture_readdata, 32'h04030201);
    pop1();
    chk("sh_w1",    cif.capture_readdata, 32'h00000005);
    pop1();
    chk("sh_empty", cif.capture_readdata, 32'h0);

    // 20x1 frame into 4 words, then back-to-back pops
    arm(16'd20, 16'd1);
    chk("ov_short_cleared", 32'(short_frame), 32'h0);
    frame(20);
    chk("ov_done", 32'(capture_done), 32'h1);
    chk("ov_flag", 32'(overflow), 32'h1);
    chk("ov_w0",   cif.capture_readdata, 32'h04030201);
    pop1();
    chk("ov_w1",   cif.capture_readdata, 32'h08070605);
    pop1();
    chk("ov_w2",   cif.capture_readdata, 32'h0C0B0A09);
    pop1();
    chk("ov_w3",   cif.capture_readdata, 32'h100F0E0D);
    pop1();
    chk("ov_empty", cif.capture_readdata, 32'h0);
    pop1();
    chk("ov_empty_pop", cif.capture_readdata, 32'h0);
    chk("ov_sticky", 32'(overflow), 32'h1);

    // reset in the middle of a capture
    arm(16'd4, 16'd2);
    cif.frame_valid = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      cif.pix_valid = 1'b1;
      cif.pix_data  = pix_tab[i];
      tick();
    end
    chk("mid_w0", cif.capture_readdata, 32'h04030201);
    capture_start = 1'b0;
    csi_reset_n   = 1'b0;
    #1;
    chk("mid_rst_readdata", cif.capture_readdata, 32'h0);
    chk("mid_rst_done",     32'(capture_done), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    chk("mid_rst_short",    32'(short_frame), 32'h0);
    cif.pix_valid   = 1'b0;
    cif.frame_valid = 1'b0;
    repeat (2) tick();
    csi_reset_n = 1'b1;
    repeat (2) tick();
    chk("post_rst_idle", 32'(capture_done), 32'h0);
    arm(16'd4, 16'd2);
    frame(8);
    chk("re_done", 32'(capture_done), 32'h1);
    chk("re_w0",   cif.capture_readdata, 32'h04030201);
    pop1();
    chk("re_w1",   cif.capture_readdata, 32'h08070605);
    pop1();
    chk("re_empty", cif.capture_readdata, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
